// File: rtl/local_mem_bank_responder.sv
// local_mem_bank_responder
//   Avalon-MM burst slave standing in for one local-memory bank. Burst
//   writes and burst reads are served from an internal word-addressed RAM
//   (2^ADDR_WIDTH words of DATA_WIDTH bits, byte-lane writable).
//
// Ports
//   clk, reset      single clock; asynchronous active-high reset
//   address         word address, sampled on command beats only
//   burstcount      burst length in beats, sampled on command beats only
//   read / write    read command / write beat valid
//   writedata       write data, byteenable gates each byte lane
//   waitrequest     slave busy; high during reset and while a read burst issues
//   readdata        read data, qualified by readdatavalid
//   readdatavalid   one pulse per returned beat, never stalled
//   response        always 2'b00
//   protocol_err    sticky flag for illegal master behaviour
module local_mem_bank_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int READ_LATENCY    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    input  logic                       read,
    input  logic                       write,
    input  logic [DATA_WIDTH-1:0]      writedata,
    input  logic [DATA_WIDTH/8-1:0]    byteenable,
    output logic                       waitrequest,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic                       readdatavalid,
    output logic [1:0]                 response,
    output logic                       protocol_err
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BURST = 2'd1;
    localparam logic [1:0] RD_BURST = 2'd2;

    localparam logic [BURST_CNT_WIDTH-1:0] BEAT_ONE = {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                 state, stateNext;
    logic [ADDR_WIDTH-1:0]      baseAddr, baseAddrNext;
    logic [BURST_CNT_WIDTH-1:0] burstLen, burstLenNext;
    logic [BURST_CNT_WIDTH-1:0] beatCnt, beatCntNext;
    logic [BURST_CNT_WIDTH-1:0] cmdLen;
    logic                       protoErrNext;
    logic                       lastBeat;

    logic                       ramWe;
    logic                       ramRe;
    logic [ADDR_WIDTH-1:0]      ramWrAddr;
    logic [ADDR_WIDTH-1:0]      ramRdAddr;
    logic [ADDR_WIDTH-1:0]      burstAddr;
    logic [DATA_WIDTH-1:0]      ramQ;
    logic                       rdIssued;

    logic [READ_LATENCY-1:0]    validPipe;
    logic [DATA_WIDTH-1:0]      dataPipe [READ_LATENCY];

    // A zero burstcount is serviced as a single beat.
    assign cmdLen    = (burstcount == '0) ? BEAT_ONE : burstcount;
    assign lastBeat  = (beatCnt == burstLen - BEAT_ONE);
    // Wraps modulo 2^ADDR_WIDTH by construction of the adder width.
    assign burstAddr = baseAddr + ADDR_WIDTH'(beatCnt);
    assign ramRdAddr = burstAddr;

    always_comb begin
        stateNext    = state;
        baseAddrNext = baseAddr;
        burstLenNext = burstLen;
        beatCntNext  = beatCnt;
        protoErrNext = protocol_err;
        ramWe        = 1'b0;
        ramRe        = 1'b0;
        ramWrAddr    = burstAddr;
        case (state)
            IDLE: begin
                if (!waitrequest) begin
                    if (write) begin
                        // Write wins over a simultaneous read; the read is dropped.
                        ramWe        = 1'b1;
                        ramWrAddr    = address;
                        baseAddrNext = address;
                        burstLenNext = cmdLen;
                        beatCntNext  = BEAT_ONE;
                        if (read || (burstcount == '0)) begin
                            protoErrNext = 1'b1;
                        end
                        if (cmdLen != BEAT_ONE) begin
                            stateNext = WR_BURST;
                        end
                    end else if (read) begin
                        baseAddrNext = address;
                        burstLenNext = cmdLen;
                        beatCntNext  = '0;
                        if (burstcount == '0) begin
                            protoErrNext = 1'b1;
                        end
                        stateNext = RD_BURST;
                    end
                end
            end
            WR_BURST: begin
                if (read) begin
                    protoErrNext = 1'b1;
                end
                if (write) begin
                    ramWe = 1'b1;
                    if (lastBeat) begin
                        stateNext = IDLE;
                    end else begin
                        beatCntNext = beatCnt + BEAT_ONE;
                    end
                end
            end
            RD_BURST: begin
                ramRe = 1'b1;
                if (lastBeat) begin
                    stateNext = IDLE;
                end else begin
                    beatCntNext = beatCnt + BEAT_ONE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baseAddr     <= '0;
            burstLen     <= BEAT_ONE;
            beatCnt      <= '0;
            protocol_err <= 1'b0;
            waitrequest  <= 1'b1;
            rdIssued     <= 1'b0;
        end else begin
            state        <= stateNext;
            baseAddr     <= baseAddrNext;
            burstLen     <= burstLenNext;
            beatCnt      <= beatCntNext;
            protocol_err <= protoErrNext;
            // Registered so it is high through reset and drops on the first edge after.
            waitrequest  <= (stateNext == RD_BURST);
            rdIssued     <= ramRe;
        end
    end

    // One RAM per byte lane so each lane's write enable maps onto its own block RAM.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            logic [7:0] laneMem [DEPTH];
            logic [7:0] laneQ;

            always_ff @(posedge clk) begin
                if (ramWe && byteenable[gi]) begin
                    laneMem[ramWrAddr] <= writedata[gi*8 +: 8];
                end
                if (ramRe) begin
                    laneQ <= laneMem[ramRdAddr];
                end
            end

            assign ramQ[gi*8 +: 8] = laneQ;
        end
    endgenerate

    // Return pipeline after the RAM output register; no backpressure, so it only shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validPipe <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                dataPipe[s] <= '0;
            end
        end else begin
            validPipe[0] <= rdIssued;
            dataPipe[0]  <= ramQ;
            for (int s = 1; s < READ_LATENCY; s++) begin
                validPipe[s] <= validPipe[s-1];
                dataPipe[s]  <= dataPipe[s-1];
            end
        end
    end

    assign readdatavalid = validPipe[READ_LATENCY-1];
    assign readdata      = dataPipe[READ_LATENCY-1];
    assign response      = 2'b00;

endmodule

// File: tb/tb_local_mem_bank_responder.sv
module tb_local_mem_bank_responder;

    localparam int AW = 10;
    localparam int DW = 512;
    localparam int BW = 7;
    localparam int RL = 4;
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic [BW-1:0] burstcount;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [NB-1:0] byteenable;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic [1:0]    response;
    logic          protocol_err;

    local_mem_bank_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .burstcount(burstcount),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .readdatavalid(readdatavalid),
        .response(response), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   nCmp = 0;
    int   nBad = 0;

    function automatic void check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {NB{b}};
    endfunction

    // Monitor: every returned beat is matched against the scoreboard head.
    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            if (sb.size() == 0) begin
                nCmp++;
                nBad++;
                $display("FAIL unexpected_beat: readdatavalid at cycle %0d data %h, none expected", cyc, readdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, readdata, e.data);
                check({e.name, "_cycle"}, DW'(cyc), DW'(e.cyc));
            end
        end
    end

    // Presents one request beat and waits (bounded) until it is accepted.
    // Entered and left #1 after a rising edge; acc is the accepting edge's cycle number.
    task automatic beat(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                        input logic [DW-1:0] d, input logic [NB-1:0] be, output int acc);
        bit ok;
        ok = 1'b0;
        read = rd; write = wr; address = a; burstcount = bc; writedata = d; byteenable = be;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (waitrequest === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nCmp++;
            nBad++;
            $display("FAIL accept_timeout: waitrequest stayed %b, required 0", waitrequest);
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic readCmd(input string name, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                           input int beats, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        int acc;
        logic [DW-1:0] dv [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        beat(1'b1, 1'b0, a, bc, '0, '0, acc);
        for (int i = 0; i < beats; i++) begin
            exp_t e;
            e.data = dv[i];
            e.cyc  = acc + 1 + RL + i;
            e.name = $sformatf("%s_b%0d", name, i);
            sb.push_back(e);
        end
    endtask

    task automatic countWait(input string name, input int required);
        int hi;
        hi = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (waitrequest !== 1'b1) break;
            hi++;
        end
        check({name, "_waitrequest_cycles"}, DW'(hi), DW'(required));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check({name, "_drained"}, DW'(sb.size()), DW'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int acc;

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; burstcount = '0;
        writedata = '0; byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", DW'(waitrequest), DW'(1));
        check("rst_readdatavalid", DW'(readdatavalid), DW'(0));
        check("rst_readdata", readdata, '0);
        check("rst_protocol_err", DW'(protocol_err), DW'(0));
        check("rst_response", DW'(response), DW'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rel_waitrequest_before_edge", DW'(waitrequest), DW'(1));
        @(posedge clk);
        #1;
        check("rel_waitrequest_after_edge", DW'(waitrequest), DW'(0));

        // Single write then read.
        beat(1'b0, 1'b1, 10'd5, 7'd1, rep(8'hA5), '1, acc);
        readCmd("single", 10'd5, 7'd1, 1, rep(8'hA5), '0, '0, '0);
        countWait("single", 1);
        drain("single");
        check("single_protocol_err", DW'(protocol_err), DW'(0));

        // Burst with a partial byteenable on beat 2; addr 10 preloaded so upper bytes are known.
        beat(1'b0, 1'b1, 10'd10, 7'd1, rep(8'h5A), '1, acc);
        for (int i = 0; i < 4; i++)
            beat(1'b0, 1'b1, 10'd8, 7'd4, DW'(i), (i == 2) ? NB'(1) : '1, acc);
        readCmd("burst", 10'd8, 7'd4, 4, DW'(0), DW'(1), {{(NB-1){8'h5A}}, 8'h02}, DW'(3));
        countWait("burst", 4);
        drain("burst");

        // Wrap-around from the top word, with an idle cycle inside the write burst.
        beat(1'b0, 1'b1, 10'd1023, 7'd3, DW'(7), '1, acc);
        beat(1'b0, 1'b1, 10'd0, 7'd0, DW'(8), '1, acc);
        idle(1);
        beat(1'b0, 1'b1, 10'd0, 7'd0, DW'(9), '1, acc);
        readCmd("wrap", 10'd1023, 7'd3, 3, DW'(7), DW'(8), DW'(9), '0);
        countWait("wrap", 3);
        drain("wrap");

        // Back-to-back reads: second command rides on the first waitrequest-low cycle.
        beat(1'b0, 1'b1, 10'd16, 7'd2, DW'(16), '1, acc);
        beat(1'b0, 1'b1, 10'd0, 7'd0, DW'(17), '1, acc);
        readCmd("b2b_a", 10'd0, 7'd2, 2, DW'(8), DW'(9), '0, '0);
        readCmd("b2b_b", 10'd16, 7'd2, 2, DW'(16), DW'(17), '0, '0);
        drain("b2b");

        // Read and write together in IDLE: write lands, no read data, sticky error.
        check("pre_err_protocol_err", DW'(protocol_err), DW'(0));
        beat(1'b1, 1'b1, 10'd20, 7'd1, rep(8'h77), '1, acc);
        idle(12);
        check("rw_protocol_err", DW'(protocol_err), DW'(1));
        check("rw_stays_idle", DW'(waitrequest), DW'(0));
        readCmd("rw_write_landed", 10'd20, 7'd1, 1, rep(8'h77), '0, '0, '0);
        drain("rw");
        check("rw_protocol_err_sticky", DW'(protocol_err), DW'(1));

        // Zero burstcount on a write: single beat, next write is a fresh command.
        beat(1'b0, 1'b1, 10'd30, 7'd0, rep(8'h33), '1, acc);
        beat(1'b0, 1'b1, 10'd40, 7'd1, rep(8'h44), '1, acc);
        readCmd("bc0w_a", 10'd30, 7'd1, 1, rep(8'h33), '0, '0, '0);
        readCmd("bc0w_b", 10'd40, 7'd1, 1, rep(8'h44), '0, '0, '0);
        drain("bc0w");

        // Reset two cycles into an 8-beat read: nothing from that burst may come back.
        beat(1'b1, 1'b0, 10'd0, 7'd8, '0, '0, acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_readdatavalid", DW'(readdatavalid), DW'(0));
        check("midrst_waitrequest", DW'(waitrequest), DW'(1));
        sb.delete();
        idle(3);
        check("midrst_waitrequest_held", DW'(waitrequest), DW'(1));
        reset = 1'b0;
        @(negedge clk);
        check("midrst_rel_before_edge", DW'(waitrequest), DW'(1));
        @(posedge clk);
        #1;
        check("midrst_rel_after_edge", DW'(waitrequest), DW'(0));
        check("midrst_protocol_err_cleared", DW'(protocol_err), DW'(0));
        idle(20);

        // Zero burstcount on a read after reset: one beat, RAM kept its contents, error set.
        readCmd("bc0r", 10'd20, 7'd0, 1, rep(8'h77), '0, '0, '0);
        countWait("bc0r", 1);
        drain("bc0r");
        check("bc0r_protocol_err", DW'(protocol_err), DW'(1));
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
